alu_mc: RTL

Multi-cycle, parametrised successor to the single-cycle 32-bit ALU in the execute stage. It keeps the compare/add/sub/shift/logic operation set and the ZVNC flags, and adds the following:
- Registered output with a valid/ready handshake on both sides.
- Generic operand width.
- An add-with-carry operation.
- An optional iterative unsigned multiply/divide unit.

It sits between the decode/issue logic and writeback, and holds at most one operation in flight.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_muldiv_iter.sv | 73 +++++++
 rtl/alu_mc.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for alu_mc: opcode encoding, FSM state encoding and the iterative opcodes.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_EQ   = 4'd0,
        OP_LT   = 4'd1,
        OP_LTU  = 4'd2,
        OP_GT   = 4'd3,
        OP_GTU  = 4'd4,
        OP_ADD  = 4'd5,
        OP_ADDC = 4'd6,
        OP_SUB  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_OR   = 4'd11,
        OP_XOR  = 4'd12,
        OP_AND  = 4'd13,
        OP_MULU = 4'd14,
        OP_DIVU = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam logic [3:0] OPC_MULU = 4'd14;
    localparam logic [3:0] OPC_DIVU = 4'd15;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative unsigned multiply (shift-add) / divide (restoring), one step per cycle.
// op=1 selects divide; result and done are valid combinationally during the final step.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic             is_div;
    // acc: product accumulator or partial remainder; opa: multiplicand or dividend/quotient; opb: multiplier or divisor
    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_n, opa_n, opb_n;
    logic [WIDTH:0]   rem_sh, diff;

    always_comb begin
        rem_sh = {acc, opa[WIDTH-1]};
        diff   = rem_sh - {1'b0, opb};
        acc_n  = acc;
        opa_n  = opa;
        opb_n  = opb;
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_n = diff[WIDTH-1:0];
                opa_n = {opa[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = rem_sh[WIDTH-1:0];
                opa_n = {opa[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = opb[0] ? (acc + opa) : acc;
            opa_n = opa << 1;
            opb_n = opb >> 1;
        end
    end

    assign done   = busy && (cnt == CW'(WIDTH - 1));
    assign result = is_div ? opa_n : acc_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            is_div <= 1'b0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op;
            acc    <= '0;
            opa    <= a;
            opb    <= b;
        end else if (busy) begin
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides and one operation in flight.
// Define ALU_MULDIV_EN to build the iterative MULU/DIVU unit; otherwise those opcodes report out_err.
//
// state | meaning
// IDLE  | empty, ready for a request
// BUSY  | iterative MULU/DIVU stepping
// DONE  | result held on out_res/flags until out_ready
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_z,
    output logic             out_v,
    output logic             out_n,
    output logic             out_c,
    output logic             out_err
);
    alu_state_e       state, state_n;
    logic [WIDTH-1:0] c_res;
    logic             c_v, c_c, c_err;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic             go_iter;
    logic             load_alu;

`ifdef ALU_MULDIV_EN
    logic             start, load_md, md_busy, md_done;
    logic [WIDTH-1:0] md_result;

    // Divide by zero never enters the iterative unit
    assign go_iter = (in_op == OPC_MULU) || ((in_op == OPC_DIVU) && (in_b != '0));

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (in_a),
        .b      (in_b),
        .op     (in_op == OPC_DIVU),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign go_iter = 1'b0;
`endif

    assign shamt = in_b[SHW-1:0];

    always_comb begin
        c_res = '0;
        c_v   = 1'b0;
        c_c   = 1'b0;
        c_err = 1'b0;
        sum   = '0;
        case (alu_op_e'(in_op))
            OP_EQ:   c_res[0] = (in_a == in_b);
            OP_LT:   c_res[0] = ($signed(in_a) < $signed(in_b));
            OP_LTU:  c_res[0] = (in_a < in_b);
            OP_GT:   c_res[0] = ($signed(in_a) > $signed(in_b));
            OP_GTU:  c_res[0] = (in_a > in_b);
            OP_ADD, OP_ADDC: begin
                sum   = {1'b0, in_a} + {1'b0, in_b}
                      + {{WIDTH{1'b0}}, (in_op == OP_ADDC) && in_cin};
                c_res = sum[WIDTH-1:0];
                c_c   = sum[WIDTH];
                c_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (c_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                sum   = {1'b0, in_a} - {1'b0, in_b};
                c_res = sum[WIDTH-1:0];
                c_c   = !sum[WIDTH];
                c_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (c_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SLL:  c_res = in_a << shamt;
            OP_SRL:  c_res = in_a >> shamt;
            OP_SRA:  c_res = $signed(in_a) >>> shamt;
            OP_OR:   c_res = in_a | in_b;
            OP_XOR:  c_res = in_a ^ in_b;
            OP_AND:  c_res = in_a & in_b;
            OP_MULU, OP_DIVU: begin
`ifdef ALU_MULDIV_EN
                // Only DIVU by zero takes this path when the unit is present
                c_res = '1;
`endif
                c_err = 1'b1;
            end
            default: c_res = '0;
        endcase
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        load_alu = 1'b0;
`ifdef ALU_MULDIV_EN
        start    = 1'b0;
        load_md  = 1'b0;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
                in_ready = (state == ST_IDLE) || out_ready;
                if (in_valid && in_ready) begin
                    if (go_iter) begin
`ifdef ALU_MULDIV_EN
                        start   = 1'b1;
`endif
                        state_n = ST_BUSY;
                    end else begin
                        load_alu = 1'b1;
                        state_n  = ST_DONE;
                    end
                end else if (state == ST_DONE && out_ready) begin
                    state_n = ST_IDLE;
                end
            end
`ifdef ALU_MULDIV_EN
            ST_BUSY: begin
                if (md_done) begin
                    load_md = 1'b1;
                    state_n = ST_DONE;
                end else if (!md_busy) begin
                    state_n = ST_IDLE;  // unit lost its operation; never strand the FSM
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            out_res <= '0;
            out_z   <= 1'b0;
            out_v   <= 1'b0;
            out_n   <= 1'b0;
            out_c   <= 1'b0;
            out_err <= 1'b0;
        end else begin
            state <= state_n;
            if (load_alu) begin
                out_res <= c_res;
                out_z   <= (c_res == '0);
                out_n   <= c_res[WIDTH-1];
                out_v   <= c_v;
                out_c   <= c_c;
                out_err <= c_err;
            end
`ifdef ALU_MULDIV_EN
            else if (load_md) begin
                out_res <= md_result;
                out_z   <= (md_result == '0);
                out_n   <= md_result[WIDTH-1];
                out_v   <= 1'b0;
                out_c   <= 1'b0;
                out_err <= 1'b0;
            end
`endif
        end
    end

endmodule
